// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit (lsu, lsu_fmt).
// The LSU_MISALIGN_TRAP_EN build uses misaligned() to reject unaligned H/W accesses.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Byte lane within a word, and the half-word select taken from its top bit
   localparam int unsigned LANE_W     = 2;
   localparam int unsigned HALF_SEL_W = 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_MERGE_WR,
      ST_RESP
   } state_e;

   typedef enum logic [1:0] {
      SZ_B,
      SZ_H,
      SZ_W
   } size_e;

   // Unlisted funct3 codes behave as full-word accesses
   function automatic size_e size_of(input logic [2:0] f3);
      case (f3)
         F3_B, F3_BU: return SZ_B;
         F3_H, F3_HU: return SZ_H;
         default:     return SZ_W;
      endcase
   endfunction

   function automatic logic misaligned(input logic [2:0] f3, input logic [LANE_W-1:0] lane);
      case (size_of(f3))
         SZ_H:    return lane[0];
         SZ_W:    return lane != '0;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_fmt.sv
// Combinational load extraction and sub-word store merge for the LSU.
module lsu_fmt
   import lsu_pkg::*;
(
   input  logic [31:0]       rd_word,
   input  logic [31:0]       buf_word,
   input  logic [31:0]       wdata,
   input  logic [LANE_W-1:0] lane,
   input  logic [2:0]        funct3,
   output logic [31:0]       load_data,
   output logic [31:0]       merge_data
);

   logic [7:0]            byte_sel;
   logic [15:0]           half_sel;
   logic [HALF_SEL_W-1:0] half_lane;

   // Half accesses ignore lane[0], which force-aligns them when the trap is absent
   assign half_lane = lane[LANE_W-1];

   always_comb begin
      byte_sel = rd_word[{lane, 3'b000} +: 8];
      half_sel = rd_word[{half_lane, 4'b0000} +: 16];
      case (size_of(funct3))
         SZ_B:    load_data = funct3[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         SZ_H:    load_data = funct3[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
         default: load_data = rd_word;
      endcase
   end

   always_comb begin
      merge_data = buf_word;
      case (size_of(funct3))
         SZ_B:    merge_data[{lane, 3'b000} +: 8]       = wdata[7:0];
         SZ_H:    merge_data[{half_lane, 4'b0000} +: 16] = wdata[15:0];
         default: merge_data = wdata;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: byte-addressed RISC-V loads/stores onto a word-only memory port.
// Optional build macro LSU_MISALIGN_TRAP_EN reports misaligned H/W accesses via resp_err.
module lsu
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_WORDS = 512
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [31:0] mem_di,
   input  logic [31:0] mem_do
);

   state_e      state_q, state_d;
   logic        we_q, we_d;
   logic [2:0]  f3_q, f3_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] buf_q, buf_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        resp_err_q, resp_err_d;
   logic [31:0] load_data, merge_data;
   logic        sw_access;

   lsu_fmt u_fmt (
      .rd_word    (mem_do),
      .buf_word   (buf_q),
      .wdata      (wdata_q),
      .lane       (addr_q[LANE_W-1:0]),
      .funct3     (f3_q),
      .load_data  (load_data),
      .merge_data (merge_data)
   );

   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      f3_d         = f3_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      buf_d        = buf_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               we_d         = req_we;
               f3_d         = req_funct3;
               addr_d       = req_addr;
               wdata_d      = req_wdata;
               resp_rdata_d = '0;
               resp_err_d   = 1'b0;
               state_d      = ST_ACCESS;
`ifdef LSU_MISALIGN_TRAP_EN
               if (misaligned(req_funct3, req_addr[LANE_W-1:0])) begin
                  resp_err_d   = 1'b1;
                  resp_valid_d = 1'b1;
                  state_d      = ST_RESP;
               end
`endif
            end
         end
         ST_ACCESS: begin
            if (!we_q) begin
               resp_rdata_d = load_data;
               resp_valid_d = 1'b1;
               state_d      = ST_RESP;
            end else if (size_of(f3_q) == SZ_W) begin
               resp_valid_d = 1'b1;
               state_d      = ST_RESP;
            end else begin
               buf_d   = mem_do;
               state_d = ST_MERGE_WR;
            end
         end
         ST_MERGE_WR: begin
            resp_valid_d = 1'b1;
            state_d      = ST_RESP;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         we_q         <= 1'b0;
         f3_q         <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         buf_q        <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         f3_q         <= f3_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         buf_q        <= buf_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   // Write strobe depends on state only, so an async reset removes it at once
   assign sw_access = (state_q == ST_ACCESS) && we_q && (size_of(f3_q) == SZ_W);
   assign mem_we    = sw_access || (state_q == ST_MERGE_WR);
   assign mem_di    = (state_q == ST_MERGE_WR) ? merge_data :
                      sw_access                ? wdata_q    : '0;
   assign mem_addr  = (state_q == ST_IDLE) ? {2'b00, req_addr[31:2]} : {2'b00, addr_q[31:2]};

   assign req_ready  = (state_q == ST_IDLE);
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

   mem_addr_in_range: assert property (@(posedge clk) disable iff (rst) mem_we |-> (mem_addr < MEM_WORDS));

endmodule

// File: tb/tb_lsu.sv
// Randomized self-checking bench for lsu against a word-array reference model.
module tb_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic [31:0] mem_addr, mem_di, mem_do;
   logic        mem_we;

   logic [31:0] memw    [512];
   logic [31:0] ref_mem [512];
   int vectors = 0;
   int miscompares = 0;

   lsu #(.MEM_WORDS(512)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_di(mem_di), .mem_do(mem_do)
   );

   always #5 clk = ~clk;

   assign mem_do = memw[mem_addr[8:0]];
   always @(posedge clk) if (mem_we) memw[mem_addr[8:0]] <= mem_di;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One sampled cycle of DUT outputs against expectations
   task automatic cyc(input string ph, input logic e_ready, input logic e_valid, input logic e_we,
                      input logic [31:0] e_di, input logic [31:0] e_rd, input logic e_err,
                      input logic [31:0] e_waddr);
      chk({ph, " req_ready"}, {31'b0, req_ready}, {31'b0, e_ready});
      chk({ph, " resp_valid"}, {31'b0, resp_valid}, {31'b0, e_valid});
      chk({ph, " mem_we"}, {31'b0, mem_we}, {31'b0, e_we});
      if (e_we) chk({ph, " mem_di"}, mem_di, e_di);
      if (e_valid) begin
         chk({ph, " resp_rdata"}, resp_rdata, e_rd);
         chk({ph, " resp_err"}, {31'b0, resp_err}, {31'b0, e_err});
      end
      if (!e_ready) chk({ph, " mem_addr"}, mem_addr, e_waddr);
   endtask

   function automatic int unsigned size_bytes(input logic [2:0] f3);
      case (f3)
         3'd0, 3'd4: return 1;
         3'd1, 3'd5: return 2;
         default:    return 4;
      endcase
   endfunction

   // Issue one request at a negedge in IDLE; returns at a negedge back in IDLE
   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output logic err);
      int unsigned sz, sh;
      logic [31:0] mask, ea, w, v, nw, exp_rd;
      logic mis;
      sz   = size_bytes(f3);
      mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
      mis  = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis  = (addr % sz) != 0;
`endif
      ea = addr - (addr % sz);
      w  = ref_mem[ea[10:2]];
      sh = 8 * (ea % 4);
      v  = (w >> sh) & mask;
      if ((f3 == 3'd0 || f3 == 3'd1) && v[8*sz-1]) v = v | ~mask;
      nw = (w & ~(mask << sh)) | ((wd & mask) << sh);
      exp_rd = (we || mis) ? 32'h0 : v;

      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      #1;
      chk("idle mem_addr", mem_addr, addr >> 2);
      chk("idle req_ready", {31'b0, req_ready}, 32'd1);
      @(posedge clk);
      #1;
      // Junk while busy must be ignored
      req_valid = 1'($urandom); req_we = 1'($urandom); req_funct3 = 3'($urandom);
      req_addr = 32'h100 + $urandom_range(0, 63); req_wdata = $urandom;
      @(negedge clk);
      if (mis) begin
         cyc("trap-resp", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, addr >> 2);
      end else begin
         cyc("access", 1'b0, 1'b0, we && sz == 4, wd, 32'h0, 1'b0, addr >> 2);
         if (we && sz != 4) begin
            @(negedge clk);
            cyc("merge", 1'b0, 1'b0, 1'b1, nw, 32'h0, 1'b0, addr >> 2);
         end
         @(negedge clk);
         cyc("resp", 1'b0, 1'b1, 1'b0, 32'h0, exp_rd, 1'b0, addr >> 2);
         if (we) ref_mem[ea[10:2]] = nw;
      end
      rd  = resp_rdata;
      err = resp_err;
      @(negedge clk);
      req_valid = 1'b0;
      cyc("done", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
   endtask

   task automatic preload();
      memw[9'h040]    = 32'h8081_7F01;
      ref_mem[9'h040] = 32'h8081_7F01;
   endtask

   logic [31:0] rd;
   logic        err;

   initial begin
      for (int i = 0; i < 512; i++) begin
         memw[i] = '0;
         ref_mem[i] = '0;
      end
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
      req_addr = 32'h0000_1234; req_wdata = '0;
      #3;
      chk("rst req_ready", {31'b0, req_ready}, 32'd1);
      chk("rst resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("rst resp_rdata", resp_rdata, 32'h0);
      chk("rst resp_err", {31'b0, resp_err}, 32'd0);
      chk("rst mem_we", {31'b0, mem_we}, 32'd0);
      chk("rst mem_di", mem_di, 32'h0);
      chk("rst mem_addr", mem_addr, 32'h0000_048D);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      preload();
      do_req(1'b0, 3'd0, 32'h102, 32'h0, rd, err); chk("LB@102", rd, 32'hFFFF_FF81);
      do_req(1'b0, 3'd4, 32'h102, 32'h0, rd, err); chk("LBU@102", rd, 32'h0000_0081);
      do_req(1'b0, 3'd1, 32'h102, 32'h0, rd, err); chk("LH@102", rd, 32'hFFFF_8081);
      do_req(1'b0, 3'd5, 32'h102, 32'h0, rd, err); chk("LHU@102", rd, 32'h0000_8081);
      do_req(1'b0, 3'd1, 32'h100, 32'h0, rd, err); chk("LH@100", rd, 32'h0000_7F01);

      preload();
      do_req(1'b1, 3'd0, 32'h101, 32'h1234_56AA, rd, err);
      chk("SB@101 word", memw[9'h040], 32'h8081_AA01);
      do_req(1'b0, 3'd2, 32'h100, 32'h0, rd, err); chk("LW@100 after SB", rd, 32'h8081_AA01);

      do_req(1'b1, 3'd2, 32'h104, 32'hDEAD_BEEF, rd, err); chk("SW rdata", rd, 32'h0);
      do_req(1'b0, 3'd2, 32'h104, 32'h0, rd, err); chk("LW@104", rd, 32'hDEAD_BEEF);

      preload();
      do_req(1'b1, 3'd1, 32'h103, 32'h0000_BEEF, rd, err);
`ifdef LSU_MISALIGN_TRAP_EN
      chk("SH@103 err", {31'b0, err}, 32'd1);
      chk("SH@103 word", memw[9'h040], 32'h8081_7F01);
`else
      chk("SH@103 err", {31'b0, err}, 32'd0);
      chk("SH@103 word", memw[9'h040], 32'hBEEF_7F01);
`endif

      // Reset while an SB sits in ACCESS
      preload();
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h100; req_wdata = 32'h55;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("rstmid access mem_we", {31'b0, mem_we}, 32'd0);
      rst = 1'b1;
      #1;
      chk("rstmid req_ready", {31'b0, req_ready}, 32'd1);
      chk("rstmid mem_we", {31'b0, mem_we}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         cyc("after-rst", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      end
      chk("rstmid word", memw[9'h040], 32'h8081_7F01);

      for (int n = 0; n < 400; n++) begin
         do_req(1'($urandom), 3'($urandom), 32'h100 + $urandom_range(0, 63), $urandom, rd, err);
      end
      for (int i = 9'h040; i < 9'h050; i++) chk("final mem", memw[i], ref_mem[i]);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the core's memory stage and the unified word-addressed instruction/data memory. It accepts byte-addressed RISC-V load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) and converts them to word-granular memory accesses. Loads are extracted and sign- or zero-extended. Sub-word stores are done as a read-modify-write, because the memory writes whole 32-bit words only. It drives the memory's data-side port (word address, write enable, write data) and consumes its combinational read data.

## Interface
- `MEM_WORDS`, default 512. Memory depth in words. Used only to size `mem_addr` checks in assertions.
- `clk`  in  1  System clock. All state changes on its rising edge.
- `rst`  in  1  Reset, asynchronous, active-high.
- `req_valid`  in  1  Request present.
- `req_ready`  out  1  Unit can accept a request. High only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RISC-V funct3. 000 B, 001 H, 010 W, 100 BU, 101 HU. Other codes are treated as W.
- `req_addr`  in  32  Byte address.
- `req_wdata`  in  32  Store data. Bytes are taken from the LSBs.
- `resp_valid`  out  1  One-cycle pulse when the request completes.
- `resp_rdata`  out  32  Load result. 0 for stores and errors.
- `resp_err`  out  1  Misaligned access. Only active when the feature is compiled in.
- `mem_addr`  out  32  Word address: latched `req_addr >> 2`.
- `mem_we`  out  1  Memory write enable.
- `mem_di`  out  32  Memory write data.
- `mem_do`  in  32  Memory combinational read data at `mem_addr`.

## Operation
- FSM states: IDLE, ACCESS, MERGE_WR, RESP.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid`: latch we, funct3, addr, wdata.
  - Misaligned with trap enabled → RESP with err set.
  - Otherwise → ACCESS.
- **ACCESS**
  - Load: register formatted `mem_do` into `resp_rdata` → RESP.
  - SW: `mem_we` = 1, `mem_di` = wdata → RESP.
  - SB/SH: capture `mem_do` into the merge buffer → MERGE_WR.
- **MERGE_WR**
  - `mem_we` = 1.
  - `mem_di` = buffer with the selected byte or half replaced by wdata[7:0] or wdata[15:0], placed at lane `addr[1:0]` (little-endian).
  - → RESP.
- **RESP**
  - `resp_valid` = 1 for exactly one cycle.
  - → IDLE.
- `mem_we` is decoded from state only. It is never asserted in IDLE or RESP.
- Load extract:
  - Byte = `mem_do[8*addr[1:0] +: 8]`.
  - Half = `mem_do[16*addr[1] +: 16]`.
  - B/H sign-extend; BU/HU zero-extend.
- `mem_addr` holds the latched word address from ACCESS through RESP. In IDLE it shows the live `req_addr >> 2`.

## Timing
- Reset values:
  - State = IDLE.
  - `req_ready` = 1.
  - `resp_valid` = 0, `resp_rdata` = 0, `resp_err` = 0.
  - `mem_we` = 0.
  - `mem_addr` = `req_addr >> 2` (combinational).
  - `mem_di` = 0.
  - Merge buffer = 0.
- Latency, counted from the accept edge to the edge that ends `resp_valid`:
  - Load and SW: 3 edges (ACCESS, RESP).
  - SB/SH: 4 edges (ACCESS, MERGE_WR, RESP).
  - Misaligned trap: 2 edges.
- Throughput: one request in flight. A new request can be accepted in the cycle after RESP.
- Reset mid-operation: the FSM returns to IDLE asynchronously and `mem_we` drops immediately. No partial write is issued after reset release.
- `req_valid` while `req_ready` = 0 is ignored. The requester must hold the request.

## Configuration
- `LSU_MISALIGN_TRAP_EN`
  - **Defined:** H/HU with `addr[0]` = 1, or W with `addr[1:0]` ≠ 0, gives `resp_err` = 1, `resp_rdata` = 0 and no memory access.
  - **Undefined:** misaligned addresses are force-aligned. H drops `addr[0]`; W drops `addr[1:0]`. `resp_err` is tied to 0.

## Structure
- `lsu_pkg`:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - FSM state enum.
  - Lane-select helper widths.
- Sub-module `lsu_fmt` (combinational):
  - `load_fmt(word, addr[1:0], funct3)` → 32-bit result.
  - `store_merge(word, wdata, addr[1:0], funct3)` → 32-bit word.
  - Instantiated once. The FSM and registers live in `lsu`.

## Test plan
Preload word 0x40 (byte 0x100) = 0x8081_7F01 for all scenarios.
- LB @0x102 → `resp_rdata` = 0xFFFF_FF81. LBU @0x102 → 0x0000_0081. `resp_valid` 3 edges after accept; `mem_we` never high.
- LH @0x102 → 0xFFFF_8081. LHU @0x102 → 0x0000_8081. LH @0x100 → 0x0000_7F01.
- SB @0x101, wdata 0x1234_56AA:
  - `mem_we` high exactly one cycle (MERGE_WR) with `mem_di` = 0x8081_AA01.
  - A following LW @0x100 returns 0x8081_AA01.
- SW @0x104, data 0xDEAD_BEEF, then back-to-back LW @0x104 → 0xDEAD_BEEF. `req_ready` is low for exactly 2 cycles per load.
- SH @0x103:
  - With `LSU_MISALIGN_TRAP_EN`: `resp_err` = 1, no `mem_we`, word unchanged.
  - Without it: written as SH @0x102 with wdata 0x0000_BEEF → word = 0xBEEF_7F01.
- `rst` pulsed while in ACCESS of SB @0x100 → no `mem_we` at any point, `req_ready` = 1 after release, `resp_valid` never pulses.
